alu_pipe_mc: RTL and testbench
==============================

// Module: alu_pipe_mc
// PURPOSE
//  Parametrised, handshaked successor to the combinational execute ALU.
//  - Registers results behind a valid/ready interface.
//  - Adds an iterative multiplier (MUL) with a configurable radix.
//  - Supports a synchronous flush, so the pipeline can kill a squashed instruction mid-operation.
//  - Sits in the EX stage between operand select and the EX/MEM latch.
// PARAMETERS
//  WIDTH  16  datapath width; power of 2, >= 8
//  MUL_K  1   multiplier bits retired per cycle; must divide WIDTH; MUL latency N = WIDTH/MUL_K
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous kill of in-flight/pending op
//  in_valid   in   1       op/operands valid
//  in_ready   out  1       block can accept this cycle
//  in_op      in   4       operation select (see BEHAVIOUR)
//  in_a       in   WIDTH   operand A
//  in_b       in   WIDTH   operand B / shift count / immediate
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer takes result
//  out_data   out  WIDTH   result
//  out_cout   out  1       carry out of the ADD/SUB/SCO adder (0 for other ops)
//  busy       out  1       MUL iteration in progress
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - State -> IDLE; out_valid=0, out_data=0, out_cout=0, busy=0.
//  - in_ready=0 while rst_n=0.
//  Ops (shift count s = in_b[log2(WIDTH)-1:0]; H = WIDTH/2):
//  - 0 ADD a+b
//  - 1 SUB b-a, computed as ~a+b+1
//  - 2 XOR
//  - 3 ANDN a&~b
//  - 4 ROL
//  - 5 SLL
//  - 6 ROR
//  - 7 SRL
//  - 8 SEQ
//  - 9 SLT signed a<b
//  - A SLE signed a<=b
//  - B SCO carry(a+b)
//  - C BTR bit-reverse a
//  - D SLBI {a[H-1:0], b[H-1:0]}
//  - E MUL low WIDTH bits of a*b; signedness irrelevant
//  - F reserved: result 0, single-cycle
//  - Compare ops (8-B) return {WIDTH-1 zeros, flag}.
//  Handshake:
//  - in_ready = rst_n & ~flush & (state==IDLE) & (~out_valid | out_ready).
//  - Accept = in_valid & in_ready.
//  - Output handoff = out_valid & out_ready.
//  - out_data and out_cout hold stable while out_valid & ~out_ready.
//  Latency:
//  - Non-MUL ops: result registered at the accept edge; out_valid=1 the next cycle.
//  - Non-MUL throughput is 1/cycle with out_ready=1.
//  - MUL: the accept edge loads multiplicand, multiplier and acc=0; state -> MUL; cnt=0.
//  - Each subsequent edge retires MUL_K multiplier bits (shift-add).
//  - On the Nth iteration edge, acc -> out_data, out_valid=1, state -> IDLE.
//  - Total MUL latency is N edges after accept.
//  - busy=1 in state MUL; in_ready=0 in state MUL.
//  FSM:
//  - IDLE -(accept MUL)-> MUL
//  - MUL -(cnt==N-1)-> IDLE
//  - Non-MUL accepts stay in IDLE.
//  - Output register is empty for the whole MUL, because accept required it to be empty or draining.
//  Flush (sync, highest priority):
//  - Next edge: state -> IDLE, out_valid=0, busy=0, cnt=0.
//  - No accept in the flush cycle.
//  - A result completing in the flush cycle is discarded.
//  Simultaneous events:
//  - Handoff and accept on the same edge: new result replaces old; out_valid stays 1.
//  - Handoff without accept: out_valid -> 0.
//  Wrap/width: all arithmetic is modulo 2^WIDTH; shift counts >= WIDTH cannot occur (s is truncated).
//  Reset mid-MUL: aborts immediately; no result is ever emitted for that op.
// TESTING
//  Test 1 (WIDTH=16): ADD a=7FFF, b=0001, out_ready=1.
//  - out_data=8000, cout=0, one cycle after accept.
//  - Then SCO a=FFFF, b=0001: out_data=0001.
//  Test 2: back-to-back stream of SUB a=0003,b=0010 -> 000D; ROR a=8001,b=0001 -> C000; SLT a=FFFF,b=0001 -> 0001.
//  - out_valid on 3 consecutive cycles.
//  Test 3: MUL a=00FF, b=0101, MUL_K=1.
//  - busy for 16 cycles; out_valid 16 edges after accept; out_data=FFFF.
//  - Repeat with MUL_K=4: latency 4.
//  Test 4: backpressure. Hold out_ready=0 for 3 cycles after a result.
//  - out_data constant; in_ready=0.
//  - Raise out_ready with in_valid=1: handoff and accept on the same edge.
//  Test 5: flush on the 5th MUL iteration cycle.
//  - No out_valid; busy=0 and in_ready=1 the following cycle.
//  - A subsequent ADD completes normally.
//  Test 6: rst_n pulsed low mid-MUL and with out_valid=1.
//  - All outputs 0 immediately.
//  - After release, WIDTH=32 MUL 0001_0000*0001_0000 -> 0000_0000.

Source files
------------

// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: handshaked EX-stage ALU. Single-cycle ops are registered at accept;
// MUL iterates shift-add, MUL_K multiplier bits per cycle; flush kills any pending work.
module alu_pipe_mc #(
   parameter int WIDTH = 16,
   parameter int MUL_K = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_cout,
   output logic             busy
);
   localparam int N     = WIDTH / MUL_K;
   localparam int SW    = $clog2(WIDTH);
   localparam int H     = WIDTH / 2;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_XOR  = 4'h2;
   localparam logic [3:0] OP_ANDN = 4'h3;
   localparam logic [3:0] OP_ROL  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_ROR  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_SEQ  = 4'h8;
   localparam logic [3:0] OP_SLT  = 4'h9;
   localparam logic [3:0] OP_SLE  = 4'hA;
   localparam logic [3:0] OP_SCO  = 4'hB;
   localparam logic [3:0] OP_BTR  = 4'hC;
   localparam logic [3:0] OP_SLBI = 4'hD;
   localparam logic [3:0] OP_MUL  = 4'hE;

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_cout_q, out_cout_d;

   logic             accept;
   logic [SW-1:0]    shamt;
   logic [SW:0]      shamt_inv;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] btr;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout;
   logic [WIDTH-1:0] pp_sum [MUL_K+1];
   logic [WIDTH-1:0] acc_step;

   assign in_ready = rst_n & ~flush & (state_q == S_IDLE) & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   assign shamt     = in_b[SW-1:0];
   // Complementary shift for rotates; equals WIDTH when shamt is 0, which shifts everything out.
   assign shamt_inv = (SW+1)'(WIDTH) - {1'b0, shamt};
   assign add_sum   = {1'b0, in_a} + {1'b0, in_b};
   assign sub_sum   = {1'b0, ~in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, 1'b1};

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_btr
      assign btr[gi] = in_a[WIDTH-1-gi];
   end

   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      case (in_op)
         OP_ADD:  begin alu_res = add_sum[WIDTH-1:0]; alu_cout = add_sum[WIDTH]; end
         OP_SUB:  begin alu_res = sub_sum[WIDTH-1:0]; alu_cout = sub_sum[WIDTH]; end
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_ANDN: alu_res = in_a & ~in_b;
         OP_ROL:  alu_res = (in_a << shamt) | (in_a >> shamt_inv);
         OP_SLL:  alu_res = in_a << shamt;
         OP_ROR:  alu_res = (in_a >> shamt) | (in_a << shamt_inv);
         OP_SRL:  alu_res = in_a >> shamt;
         OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
         OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) <= $signed(in_b)};
         OP_SCO:  begin alu_res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]}; alu_cout = add_sum[WIDTH]; end
         OP_BTR:  alu_res = btr;
         OP_SLBI: alu_res = {in_a[H-1:0], in_b[H-1:0]};
         default: alu_res = '0;
      endcase
   end

   // One radix-2^MUL_K step: add the multiplicand for each set low multiplier bit.
   assign pp_sum[0] = acc_q;
   for (genvar gi = 0; gi < MUL_K; gi++) begin : g_pp
      assign pp_sum[gi+1] = pp_sum[gi] + (mplier_q[gi] ? (mcand_q << gi) : '0);
   end
   assign acc_step = pp_sum[MUL_K];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_cout_d  = out_cout_q;
      if (flush) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (in_op == OP_MUL) begin
                     state_d  = S_MUL;
                     cnt_d    = '0;
                     mcand_d  = in_a;
                     mplier_d = in_b;
                     acc_d    = '0;
                  end else begin
                     out_valid_d = 1'b1;
                     out_data_d  = alu_res;
                     out_cout_d  = alu_cout;
                  end
               end
            end
            S_MUL: begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << MUL_K;
               mplier_d = mplier_q >> MUL_K;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N-1)) begin
                  state_d     = S_IDLE;
                  cnt_d       = '0;
                  out_valid_d = 1'b1;
                  out_data_d  = acc_step;
                  out_cout_d  = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cout_q  <= out_cout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_cout  = out_cout_q;
   assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Bench for alu_pipe_mc: vector table, MUL latency, backpressure, flush, reset and
// a randomized stream against a plain-arithmetic reference model (three configurations).
module tb_alu_pipe_mc;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // A: WIDTH=16, MUL_K=1
   logic fl_a, iv_a, ir_a, ov_a, ordy_a, oc_a, bz_a;
   logic [3:0]  op_a;
   logic [15:0] a_a, b_a, od_a;
   // B: WIDTH=16, MUL_K=4
   logic fl_b, iv_b, ir_b, ov_b, ordy_b, oc_b, bz_b;
   logic [3:0]  op_b;
   logic [15:0] a_b, b_b, od_b;
   // C: WIDTH=32, MUL_K=1
   logic fl_c, iv_c, ir_c, ov_c, ordy_c, oc_c, bz_c;
   logic [3:0]  op_c;
   logic [31:0] a_c, b_c, od_c;

   alu_pipe_mc #(.WIDTH(16), .MUL_K(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
      .in_op(op_a), .in_a(a_a), .in_b(b_a), .out_valid(ov_a), .out_ready(ordy_a),
      .out_data(od_a), .out_cout(oc_a), .busy(bz_a));
   alu_pipe_mc #(.WIDTH(16), .MUL_K(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
      .in_op(op_b), .in_a(a_b), .in_b(b_b), .out_valid(ov_b), .out_ready(ordy_b),
      .out_data(od_b), .out_cout(oc_b), .busy(bz_b));
   alu_pipe_mc #(.WIDTH(32), .MUL_K(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(fl_c), .in_valid(iv_c), .in_ready(ir_c),
      .in_op(op_c), .in_a(a_c), .in_b(b_c), .out_valid(ov_c), .out_ready(ordy_c),
      .out_data(od_c), .out_cout(oc_c), .busy(bz_c));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model for the 16-bit configuration, from the op definitions.
   function automatic void ref16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] d, output logic c);
      int unsigned ua, ub, s, t;
      ua = a; ub = b; s = b[3:0]; t = 0;
      d = 16'h0; c = 1'b0;
      case (op)
         4'h0: begin t = ua + ub; d = t[15:0]; c = t[16]; end
         4'h1: begin t = (ua ^ 32'hFFFF) + ub + 1; d = t[15:0]; c = t[16]; end
         4'h2: d = a ^ b;
         4'h3: d = a & ~b;
         4'h4: begin t = (ua << s) | (ua >> (16 - s)); d = t[15:0]; end
         4'h5: begin t = ua << s; d = t[15:0]; end
         4'h6: begin t = (ua >> s) | (ua << (16 - s)); d = t[15:0]; end
         4'h7: begin t = ua >> s; d = t[15:0]; end
         4'h8: d = {15'h0, a == b};
         4'h9: d = {15'h0, $signed(a) < $signed(b)};
         4'hA: d = {15'h0, $signed(a) <= $signed(b)};
         4'hB: begin t = ua + ub; d = {15'h0, t[16]}; c = t[16]; end
         4'hC: for (int i = 0; i < 16; i++) d[i] = a[15-i];
         4'hD: d = {a[7:0], b[7:0]};
         4'hE: begin t = ua * ub; d = t[15:0]; end
         default: d = 16'h0;
      endcase
   endfunction

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        c;
   } vec_t;
   vec_t vt[$];

   logic [15:0] exp_d[$];
   logic        exp_c[$];

   initial begin
      logic [15:0] rd, held;
      logic        rc, bad;
      int          n_acc;

      vt.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0});
      vt.push_back('{4'hB, 16'hFFFF, 16'h0001, 16'h0001, 1'b1});
      vt.push_back('{4'h1, 16'h0003, 16'h0010, 16'h000D, 1'b1});
      vt.push_back('{4'h6, 16'h8001, 16'h0001, 16'hC000, 1'b0});
      vt.push_back('{4'h9, 16'hFFFF, 16'h0001, 16'h0001, 1'b0});
      vt.push_back('{4'h2, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0});
      vt.push_back('{4'h3, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0});
      vt.push_back('{4'h4, 16'h8001, 16'h0001, 16'h0003, 1'b0});
      vt.push_back('{4'h5, 16'h0001, 16'h0014, 16'h0010, 1'b0});
      vt.push_back('{4'h7, 16'h8000, 16'h001F, 16'h0001, 1'b0});
      vt.push_back('{4'h8, 16'h1234, 16'h1234, 16'h0001, 1'b0});
      vt.push_back('{4'h8, 16'h1234, 16'h1235, 16'h0000, 1'b0});
      vt.push_back('{4'hA, 16'h0005, 16'h0005, 16'h0001, 1'b0});
      vt.push_back('{4'hA, 16'h0006, 16'h0005, 16'h0000, 1'b0});
      vt.push_back('{4'h9, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
      vt.push_back('{4'hC, 16'h0001, 16'h0000, 16'h8000, 1'b0});
      vt.push_back('{4'hD, 16'h12AB, 16'h34CD, 16'hABCD, 1'b0});
      vt.push_back('{4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b0});
      vt.push_back('{4'h1, 16'h0000, 16'h0000, 16'h0000, 1'b1});
      vt.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1});
      vt.push_back('{4'h4, 16'h1234, 16'h0010, 16'h1234, 1'b0});
      vt.push_back('{4'hB, 16'h0001, 16'h0001, 16'h0000, 1'b0});

      rst_n = 1'b0;
      fl_a = 0; iv_a = 1; op_a = 4'h0; a_a = 16'h1; b_a = 16'h1; ordy_a = 1;
      fl_b = 0; iv_b = 0; op_b = 4'h0; a_b = 16'h0; b_b = 16'h0; ordy_b = 1;
      fl_c = 0; iv_c = 0; op_c = 4'h0; a_c = 32'h0; b_c = 32'h0; ordy_c = 1;

      // Reset state
      #12;
      chk("rst_out_valid", ov_a, 0);
      chk("rst_out_data", od_a, 0);
      chk("rst_out_cout", oc_a, 0);
      chk("rst_busy", bz_a, 0);
      chk("rst_in_ready", ir_a, 0);
      #10 rst_n = 1'b1;
      iv_a = 0;
      @(posedge clk); #1;

      // Vector table as a back-to-back stream
      for (int i = 0; i < vt.size(); i++) begin
         iv_a = 1; op_a = vt[i].op; a_a = vt[i].a; b_a = vt[i].b;
         @(negedge clk);
         chk("tbl_in_ready", ir_a, 1);
         if (i > 0) begin
            $display("[TB] vec %0d op=%h a=%h b=%h -> %h c=%b", i-1, vt[i-1].op, vt[i-1].a, vt[i-1].b, od_a, oc_a);
            chk("tbl_valid", ov_a, 1);
            chk("tbl_data", od_a, vt[i-1].d);
            chk("tbl_cout", oc_a, vt[i-1].c);
         end
         @(posedge clk); #1;
      end
      iv_a = 0;
      @(negedge clk);
      chk("tbl_last_valid", ov_a, 1);
      chk("tbl_last_data", od_a, vt[vt.size()-1].d);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_drain_valid", ov_a, 0);
      @(posedge clk); #1;

      // MUL, MUL_K=1: 16 busy cycles
      iv_a = 1; op_a = 4'hE; a_a = 16'h00FF; b_a = 16'h0101;
      @(negedge clk); chk("mul1_in_ready", ir_a, 1);
      @(posedge clk); #1; iv_a = 1; op_a = 4'h0;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (bz_a !== 1'b1 || ov_a !== 1'b0 || ir_a !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      iv_a = 0;
      chk("mul1_busy_window", bad, 0);
      @(negedge clk);
      $display("[TB] mul k=1 00ff*0101 -> %h", od_a);
      chk("mul1_valid", ov_a, 1);
      chk("mul1_data", od_a, 16'hFFFF);
      chk("mul1_busy_done", bz_a, 0);
      @(posedge clk); #1;

      // MUL, MUL_K=4: 4 busy cycles
      iv_b = 1; op_b = 4'hE; a_b = 16'h00FF; b_b = 16'h0101;
      @(posedge clk); #1; iv_b = 0;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bz_b !== 1'b1 || ov_b !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      chk("mul4_busy_window", bad, 0);
      @(negedge clk);
      $display("[TB] mul k=4 00ff*0101 -> %h", od_b);
      chk("mul4_valid", ov_b, 1);
      chk("mul4_data", od_b, 16'hFFFF);
      @(posedge clk); #1;

      // Backpressure
      ordy_a = 0; iv_a = 1; op_a = 4'h0; a_a = 16'h0001; b_a = 16'h0002;
      @(posedge clk); #1;
      op_a = 4'h2; a_a = 16'h00FF; b_a = 16'h0F0F;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", ov_a, 1);
         chk("bp_data_hold", od_a, 16'h0003);
         chk("bp_in_ready", ir_a, 0);
         @(posedge clk); #1;
      end
      ordy_a = 1;
      @(negedge clk); chk("bp_release_ready", ir_a, 1);
      @(posedge clk); #1; iv_a = 0;
      @(negedge clk);
      $display("[TB] backpressure swap -> %h", od_a);
      chk("bp_swap_valid", ov_a, 1);
      chk("bp_swap_data", od_a, 16'h0FF0);
      @(posedge clk); #1;

      // Flush on the 5th MUL iteration cycle
      iv_a = 1; op_a = 4'hE; a_a = 16'h1234; b_a = 16'h5678;
      @(posedge clk); #1; iv_a = 0;
      repeat (4) begin @(posedge clk); #1; end
      fl_a = 1;
      @(negedge clk);
      chk("fl_in_ready_during", ir_a, 0);
      chk("fl_busy_during", bz_a, 1);
      @(posedge clk); #1; fl_a = 0;
      @(negedge clk);
      chk("fl_busy_after", bz_a, 0);
      chk("fl_in_ready_after", ir_a, 1);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); if (ov_a !== 1'b0 || bz_a !== 1'b0) bad = 1;
      end
      chk("fl_no_result", bad, 0);
      @(posedge clk); #1;
      iv_a = 1; op_a = 4'h0; a_a = 16'h1111; b_a = 16'h2222;
      @(posedge clk); #1; iv_a = 0;
      @(negedge clk);
      chk("fl_add_valid", ov_a, 1);
      chk("fl_add_data", od_a, 16'h3333);
      @(posedge clk); #1;

      // Flush in the MUL's completing cycle, and flush of a held result
      iv_b = 1; op_b = 4'hE; a_b = 16'h0003; b_b = 16'h0007;
      @(posedge clk); #1; iv_b = 0;
      repeat (3) begin @(posedge clk); #1; end
      fl_b = 1;
      @(posedge clk); #1; fl_b = 0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); if (ov_b !== 1'b0) bad = 1;
      end
      chk("fl_last_iter_discard", bad, 0);
      @(posedge clk); #1;
      ordy_b = 0; iv_b = 1; op_b = 4'h2; a_b = 16'h00F0; b_b = 16'h000F;
      @(posedge clk); #1; iv_b = 0; fl_b = 1;
      @(negedge clk); chk("fl_held_before", ov_b, 1);
      @(posedge clk); #1; fl_b = 0;
      @(negedge clk); chk("fl_held_killed", ov_b, 0);
      @(posedge clk); #1; ordy_b = 1;

      // Randomized stream against the reference model
      n_acc = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         iv_a   = ($urandom_range(0, 9) < 7);
         op_a   = 4'($urandom_range(0, 15));
         a_a    = 16'($urandom);
         b_a    = 16'($urandom);
         ordy_a = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (ov_a && ordy_a) begin
            if (exp_d.size() == 0) begin
               chk("rnd_spurious_valid", 1, 0);
            end else begin
               rd = exp_d.pop_front(); rc = exp_c.pop_front();
               $display("[TB] rnd handoff %h c=%b (exp %h c=%b)", od_a, oc_a, rd, rc);
               chk("rnd_data", od_a, rd);
               chk("rnd_cout", oc_a, rc);
            end
         end
         if (iv_a && ir_a) begin
            ref16(op_a, a_a, b_a, rd, rc);
            exp_d.push_back(rd); exp_c.push_back(rc);
            n_acc++;
         end
         @(posedge clk); #1;
      end
      iv_a = 0; ordy_a = 1;
      for (int k = 0; k < 40 && exp_d.size() > 0; k++) begin
         @(negedge clk);
         if (ov_a) begin
            rd = exp_d.pop_front(); rc = exp_c.pop_front();
            chk("rnd_drain_data", od_a, rd);
            chk("rnd_drain_cout", oc_a, rc);
         end
         @(posedge clk); #1;
      end
      chk("rnd_queue_empty", exp_d.size(), 0);
      chk("rnd_enough_accepts", n_acc >= 40, 1);

      // Reset mid-MUL (A) and with a held result (B)
      ordy_b = 0; iv_b = 1; op_b = 4'h0; a_b = 16'h0005; b_b = 16'h0006;
      iv_a = 1; op_a = 4'hE; a_a = 16'h0003; b_a = 16'h0005;
      @(posedge clk); #1; iv_a = 0; iv_b = 0;
      @(negedge clk);
      chk("rst_pre_b_valid", ov_b, 1);
      chk("rst_pre_a_busy", bz_a, 1);
      held = od_a;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_a_busy", bz_a, 0);
      chk("rst_async_a_valid", ov_a, 0);
      chk("rst_async_a_data", od_a, 0);
      chk("rst_async_a_ready", ir_a, 0);
      chk("rst_async_b_valid", ov_b, 0);
      chk("rst_async_b_data", od_b, 0);
      chk("rst_async_b_cout", oc_b, 0);
      @(posedge clk); #3;
      rst_n = 1'b1; ordy_b = 1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); if (ov_a !== 1'b0 || bz_a !== 1'b0) bad = 1;
      end
      chk("rst_mul_aborted", bad, 0);
      $display("[TB] reset abort, data before reset was %h", held);
      @(posedge clk); #1;

      // WIDTH=32 MULs
      iv_c = 1; op_c = 4'hE; a_c = 32'h0001_0000; b_c = 32'h0001_0000;
      @(posedge clk); #1; iv_c = 0;
      bad = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk); if (bz_c !== 1'b1 || ov_c !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      chk("w32_busy_window", bad, 0);
      @(negedge clk);
      $display("[TB] w32 mul 00010000*00010000 -> %h", od_c);
      chk("w32_valid", ov_c, 1);
      chk("w32_data", od_c, 32'h0);
      @(posedge clk); #1;
      iv_c = 1; op_c = 4'hE; a_c = 32'h0001_0003; b_c = 32'h0000_0005;
      @(posedge clk); #1; iv_c = 0;
      repeat (31) begin @(posedge clk); #1; end
      @(negedge clk); chk("w32b_not_early", ov_c, 0);
      @(posedge clk); #1;
      @(negedge clk);
      $display("[TB] w32 mul 00010003*00000005 -> %h", od_c);
      chk("w32b_valid", ov_c, 1);
      chk("w32b_data", od_c, 32'h0005_000F);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
